// File: rtl/regfile_arbiter_if.sv
// Requester-side handshake bundle for regfile_arbiter: requests, grants and read-return
// signals for both requesters A and B.
interface regfile_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req_a;
  logic             we_a;
  logic [2:0]       addr_a;
  logic [WIDTH-1:0] wdata_a;
  logic             gnt_a;
  logic [WIDTH-1:0] rdata_a;
  logic             rvalid_a;

  logic             req_b;
  logic             we_b;
  logic [2:0]       addr_b;
  logic [WIDTH-1:0] wdata_b;
  logic             gnt_b;
  logic [WIDTH-1:0] rdata_b;
  logic             rvalid_b;

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    input  gnt_a, rdata_a, rvalid_a,
    input  gnt_b, rdata_b, rvalid_b
  );

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    output gnt_a, rdata_a, rvalid_a,
    output gnt_b, rdata_b, rvalid_b
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-requester arbiter in front of a single-write-port register file: zero-fills the
// file after reset, then grants one access per cycle with round-robin tie-breaking.
module regfile_arbiter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  regfile_arbiter_if.slave bus,
  output logic             busy,
  output logic [WIDTH-1:0] rf_din,
  output logic [2:0]       rf_wa,
  output logic [2:0]       rf_ra,
  output logic             rf_wr_enable,
  input  logic [WIDTH-1:0] rf_dout
);

  localparam int       AW    = 3;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
  localparam logic     PTR_A = 1'b0;
  localparam logic     PTR_B = 1'b1;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_INIT  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [AW-1:0]    count_r;
  logic             rr_ptr_r;
  logic             gnt_a_s;
  logic             gnt_b_s;
  logic [WIDTH-1:0] rdata_a_r;
  logic [WIDTH-1:0] rdata_b_r;
  logic             rvalid_a_r;
  logic             rvalid_b_r;

  // Next-state, grant selection and register-file port steering.
  always_comb begin
    next_state_s = state_r;
    gnt_a_s      = 1'b0;
    gnt_b_s      = 1'b0;
    busy         = 1'b0;
    rf_wr_enable = 1'b0;
    rf_wa        = 3'd0;
    rf_ra        = 3'd0;
    rf_din       = {WIDTH{1'b0}};
    case (state_r)
      S_RESET: begin
        busy         = 1'b1;
        next_state_s = S_INIT;
      end
      S_INIT: begin
        busy         = 1'b1;
        rf_wr_enable = 1'b1;
        rf_wa        = count_r;
        if (count_r == LAST) begin
          next_state_s = S_RUN;
        end else begin
          next_state_s = S_INIT;
        end
      end
      S_RUN: begin
        // A wins when alone or when the pointer names A; otherwise B takes any request.
        if (bus.req_a && (!bus.req_b || (rr_ptr_r == PTR_A))) begin
          gnt_a_s = 1'b1;
        end else if (bus.req_b) begin
          gnt_b_s = 1'b1;
        end else begin
          gnt_a_s = 1'b0;
          gnt_b_s = 1'b0;
        end

        if (gnt_a_s) begin
          if (bus.we_a) begin
            rf_wr_enable = 1'b1;
            rf_wa        = bus.addr_a;
            rf_din       = bus.wdata_a;
          end else begin
            rf_ra        = bus.addr_a;
          end
        end else if (gnt_b_s) begin
          if (bus.we_b) begin
            rf_wr_enable = 1'b1;
            rf_wa        = bus.addr_b;
            rf_din       = bus.wdata_b;
          end else begin
            rf_ra        = bus.addr_b;
          end
        end else begin
          rf_wr_enable = 1'b0;
        end
      end
      default: begin
        next_state_s = S_RESET;
      end
    endcase
  end

  // State register and init sweep counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= S_RESET;
      count_r <= {AW{1'b0}};
    end else begin
      state_r <= next_state_s;
      if ((state_r == S_INIT) && (count_r != LAST)) begin
        count_r <= count_r + 3'd1;
      end else begin
        count_r <= {AW{1'b0}};
      end
    end
  end

  // Round-robin pointer: after any grant the other requester has priority.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rr_ptr_r <= PTR_A;
    end else if (gnt_a_s) begin
      rr_ptr_r <= PTR_B;
    end else if (gnt_b_s) begin
      rr_ptr_r <= PTR_A;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Read-return registers; data holds until the next granted read of that side.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rdata_a_r  <= {WIDTH{1'b0}};
      rdata_b_r  <= {WIDTH{1'b0}};
      rvalid_a_r <= 1'b0;
      rvalid_b_r <= 1'b0;
    end else begin
      rvalid_a_r <= gnt_a_s && !bus.we_a;
      rvalid_b_r <= gnt_b_s && !bus.we_b;
      if (gnt_a_s && !bus.we_a) begin
        rdata_a_r <= rf_dout;
      end
      if (gnt_b_s && !bus.we_b) begin
        rdata_b_r <= rf_dout;
      end
    end
  end

  assign bus.gnt_a    = gnt_a_s;
  assign bus.gnt_b    = gnt_b_s;
  assign bus.rdata_a  = rdata_a_r;
  assign bus.rdata_b  = rdata_b_r;
  assign bus.rvalid_a = rvalid_a_r;
  assign bus.rvalid_b = rvalid_b_r;

endmodule
